mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 one-bit mux path between four requesters and generates its 2-bit select.
- Registered one-hot grant plus encoded select; the select output drives the mux `sel[1:0]` directly.
- A grant is held until the owner drops its request, with optional forced rotation on a hold timeout.
- Sits between the requesting units and the shared 4:1 mux in the datapath.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one owner may hold the grant when others are waiting (used only with the timeout feature); legal range 2..15.
- CNT_W, 4: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; bit i = requester i wants the mux path.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  encoded index of the current owner, registered; drives mux select.
- busy  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on a forced handoff.

Behaviour:
- Reset (async assert, sync release):
  - gnt=0000, sel=00, busy=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
  - Assertion mid-grant clears everything immediately, with no handoff.
- State IDLE:
  - At each edge, if req!=0, grant the first set bit searching ptr, ptr+1, ... mod 4. Go to GRANT, set gnt/sel/busy, hold counter=0.
  - Latency is one cycle: req sampled high at edge n gives gnt at edge n.
  - If req=0, stay in IDLE with outputs 0.
- State GRANT (owner o = sel):
  - req[o]=1: hold gnt, sel unchanged; hold counter increments and saturates at MAX_HOLD.
  - req[o]=0: release. Set ptr=o+1 mod 4 and search pending req starting at ptr.
    - If a requester is found, hand off directly in the same edge (GRANT->GRANT, no idle bubble) and reset the hold counter.
    - If none is found, go to IDLE: gnt=0000, busy=0, sel keeps its last value.
- Requests from non-owners never preempt the owner, except through the timeout feature.
- sel is always the binary encoding of the one-hot gnt while busy=1. gnt is never multi-hot.
- Simultaneous release and new requests are handled as the handoff case above. The owner's own bit is excluded because it is 0.
- Fairness: after owner o releases, o has the lowest priority in the next search.
- A requester that drops req before being granted is simply skipped; no request is latched.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when the hold counter reaches MAX_HOLD-1 with req[o] still 1 and at least one other req bit set, force a handoff at the next edge.
  - The forced handoff uses ptr=o+1 and the same search as a release. timeout pulses 1 for exactly that cycle.
  - If no other request is pending, the owner keeps the grant and the counter saturates.
  - The former owner re-enters arbitration normally.
- Not defined:
  - The hold counter and its logic are not built. The owner holds the grant indefinitely.
  - timeout is tied to 0. MAX_HOLD and CNT_W are ignored.

Test Plan:
- Reset: drive rst_n=0 mid-grant with req=1111 -> gnt=0000, sel=00, busy=0 immediately (async). After release with req=0100 -> gnt=0100, sel=10 one edge later.
- Single requester: req=0010 for 5 cycles, then 0000 -> gnt=0010, sel=01 for 5 cycles, then gnt=0000, busy=0, sel stays 01.
- Round-robin: req=1111, each owner drops req one cycle after being granted and re-raises it one cycle later -> grant order 0,1,2,3,0 with no idle cycle between owners.
- Handoff skip: owner 1 releases with req=1001 pending -> next gnt=1000 (index 3 searched before 0), sel=11.
- No preemption (macro undefined): owner 0 holds req for 20 cycles with req[2]=1 -> gnt=0001 all 20 cycles, timeout=0.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): owner 0 holds with req[2]=1 -> gnt switches to 0100 after the 4th held cycle and timeout=1 for that one cycle. With req=0001 only, no forced switch.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 one-bit mux; grants are held until released.
// Optional forced rotation on hold timeout is compiled in with `define ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  // Handshake: req[i] is a level; requester i owns the mux path for every cycle gnt[i]=1
  // and gives it back by dropping req[i]. Requests are never latched.

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic       timeout_q, timeout_d;
  logic [1:0] search_start;
  logic [2:0] pick;

  if (MAX_HOLD < 2 || MAX_HOLD > 15 || (1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("mux4_rr_arbiter: MAX_HOLD must be 2..15 and fit in CNT_W bits");
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Returns {found, index}: first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign search_start = (state_q == S_IDLE) ? ptr_q : sel_q + 2'd1;
  assign pick         = rr_pick(req, search_start);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick[2]) begin
          state_d = S_GRANT;
          gnt_d   = 4'b0001 << pick[1:0];
          sel_d   = pick[1:0];
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_GRANT: begin
        if (!req[sel_q]) begin
          // Released owner drops to lowest priority for the next search.
          ptr_d = sel_q + 2'd1;
          if (pick[2]) begin
            gnt_d = 4'b0001 << pick[1:0];
            sel_d = pick[1:0];
`ifdef ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
          end else begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q >= CNT_W'(MAX_HOLD - 1) && |(req & ~gnt_q)) begin
          // Search starts past the owner, so with another request pending it cannot win again.
          ptr_d     = sel_q + 2'd1;
          gnt_d     = 4'b0001 << pick[1:0];
          sel_d     = pick[1:0];
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      ptr_q     <= 2'b00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // busy is the FSM state seen from outside.
  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = (state_q == S_GRANT);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter; each vector checks {gnt, sel, busy, timeout}.
// Timeout vectors are used when ARB_TIMEOUT_EN is defined, no-preemption vectors otherwise.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {gnt, sel, busy, timeout};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed gnt_sel_busy_to=%b expected %b", tag, obs, exp);
    end
  endtask

  // Apply req, take one rising edge, sample 1 time unit later.
  task automatic cyc(input logic [3:0] r, input string tag, input logic [7:0] exp);
    req = r;
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 8'b0000_00_0_0);
    @(negedge clk) rst_n = 1'b1;

    // single requester 1, ptr=0
    for (int i = 0; i < 5; i++) cyc(4'b0010, "single_hold", 8'b0010_01_1_0);
    cyc(4'b0000, "single_release", 8'b0000_01_0_0);
    cyc(4'b0000, "idle_sel_kept",  8'b0000_01_0_0);

    // ptr=2: owner 1 releases with 1001 pending -> 3 searched before 0
    cyc(4'b0010, "skip_grant1",  8'b0010_01_1_0);
    cyc(4'b1001, "skip_handoff", 8'b1000_11_1_0);
    cyc(4'b0000, "skip_release", 8'b0000_11_0_0);

    // ptr=0: rotating release, no idle bubble
    cyc(4'b1111, "rr_0",       8'b0001_00_1_0);
    cyc(4'b1110, "rr_1",       8'b0010_01_1_0);
    cyc(4'b1101, "rr_2",       8'b0100_10_1_0);
    cyc(4'b1011, "rr_3",       8'b1000_11_1_0);
    cyc(4'b0111, "rr_0_again", 8'b0001_00_1_0);
    cyc(4'b0000, "rr_idle",    8'b0000_00_0_0);

    // ptr=1: async reset in the middle of a grant
    cyc(4'b1111, "pre_reset", 8'b0010_01_1_0);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 8'b0000_00_0_0);
    @(posedge clk);
    #1 chk("reset_held", 8'b0000_00_0_0);
    req = 4'b0100;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_reset", 8'b0100_10_1_0);

    // owner 2 releases -> ptr=3; then requester 0 takes the path
    cyc(4'b0000, "release2", 8'b0000_10_0_0);
    cyc(4'b0001, "own0",     8'b0001_00_1_0);

`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) cyc(4'b0101, "hold_before_to", 8'b0001_00_1_0);
    cyc(4'b0101, "forced_handoff", 8'b0100_10_1_1);
    cyc(4'b0101, "to_pulse_end",   8'b0100_10_1_0);
    cyc(4'b0001, "back_to_0",      8'b0001_00_1_0);
`else
    for (int i = 0; i < 20; i++) cyc(4'b0101, "no_preempt", 8'b0001_00_1_0);
`endif
    for (int i = 0; i < 10; i++) cyc(4'b0001, "solo_hold", 8'b0001_00_1_0);
    cyc(4'b0000, "final_idle", 8'b0000_00_0_0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
